// File: rtl/mm_pkg.sv
// Shared parameters and FSM state type for the array multiplier datapath
// (input loader, core and result serializer).
package mm_pkg;

  localparam int N_ELEM = 9;
  localparam int RES_W  = 18;
  localparam int BYTE_W = 8;
  localparam int BPW    = (RES_W + BYTE_W - 1) / BYTE_W;
  localparam int TOTAL  = N_ELEM * BPW;
  localparam int EXT_W  = BPW * BYTE_W;
  localparam int WIDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/result_byte_mux.sv
// Combinational byte selector: picks byte (word_idx, byte_idx) out of a
// zero-extended word image, most-significant byte of each word first.
module result_byte_mux
  import mm_pkg::*;
(
  input  logic [N_ELEM*EXT_W-1:0] snap_i,
  input  logic [WIDX_W-1:0]       word_idx_i,
  input  logic [BIDX_W-1:0]       byte_idx_i,
  output logic [BYTE_W-1:0]       byte_o
);

  logic [BYTE_W-1:0] byte_tbl [TOTAL];
  logic [IDX_W-1:0]  flat_idx;

  // Flatten into transmit order so the select is a single array lookup.
  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_word
      for (genvar gk = 0; gk < BPW; gk++) begin : g_byte
        assign byte_tbl[gi*BPW + gk] = snap_i[gi*EXT_W + (BPW-1-gk)*BYTE_W +: BYTE_W];
      end
    end
  endgenerate

  assign flat_idx = IDX_W'(word_idx_i) * IDX_W'(BPW) + IDX_W'(byte_idx_i);
  assign byte_o   = (flat_idx < IDX_W'(TOTAL)) ? byte_tbl[flat_idx] : '0;

endmodule

// File: rtl/result_serializer.sv
// Snapshots the product matrix on start and streams it out one byte per
// valid/ready transfer, word 0 first, MS byte of each word first.
module result_serializer
  import mm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N_ELEM*RES_W-1:0] C_flat,
  output logic [BYTE_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  state_e                  state_q, state_d;
  logic [WIDX_W-1:0]       word_idx_q, word_idx_d;
  logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [N_ELEM*EXT_W-1:0] snap_q, snap_d;
  logic [BYTE_W-1:0]       out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  logic [N_ELEM*EXT_W-1:0] c_ext;
  logic [N_ELEM*EXT_W-1:0] mux_src;
  logic [WIDX_W-1:0]       mux_word, next_word;
  logic [BIDX_W-1:0]       mux_byte, next_byte;
  logic [BYTE_W-1:0]       mux_out;
  logic                    last_in_word, last_xfer, xfer;

  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_ext
      assign c_ext[gi*EXT_W +: EXT_W] = EXT_W'(C_flat[gi*RES_W +: RES_W]);
    end
  endgenerate

  // In IDLE the mux looks at the live input so byte 0 is registered on the
  // same edge that captures the snapshot; otherwise it fetches the next byte.
  always_comb begin
    last_in_word = (byte_idx_q == BIDX_W'(BPW-1));
    last_xfer    = last_in_word && (word_idx_q == WIDX_W'(N_ELEM-1));
    xfer         = out_valid_q && out_ready;
    next_byte    = last_in_word ? '0 : byte_idx_q + BIDX_W'(1);
    next_word    = last_in_word ? word_idx_q + WIDX_W'(1) : word_idx_q;
    if (state_q == IDLE) begin
      mux_src  = c_ext;
      mux_word = '0;
      mux_byte = '0;
    end else begin
      mux_src  = snap_q;
      mux_word = next_word;
      mux_byte = next_byte;
    end
  end

  result_byte_mux u_byte_mux (
    .snap_i     (mux_src),
    .word_idx_i (mux_word),
    .byte_idx_i (mux_byte),
    .byte_o     (mux_out)
  );

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    snap_d      = snap_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d      = c_ext;
          word_idx_d  = '0;
          byte_idx_d  = '0;
          out_data_d  = mux_out;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_xfer) begin
            word_idx_d  = '0;
            byte_idx_d  = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            state_d     = FIN;
          end else begin
            word_idx_d  = next_word;
            byte_idx_d  = next_byte;
            out_data_d  = mux_out;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      snap_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      snap_q      <= snap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SEND);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: table-driven frames, hand-written
// reset/restart corner cases and random frames against a byte-order model.
module tb_result_serializer;
  import mm_pkg::*;

  typedef logic [N_ELEM-1:0][RES_W-1:0] words_t;

  localparam int M_ALL1   = 0;
  localparam int M_TOGGLE = 1;
  localparam int M_STALL  = 2;
  localparam int M_RAND   = 3;

  typedef struct {
    words_t c;
    words_t alt;
    int     mode;
    int     restart_at;
    int     exp_busy;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [N_ELEM*RES_W-1:0] C_flat;
  logic [BYTE_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    done;

  int tests_run    = 0;
  int tests_failed = 0;

  result_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .C_flat    (C_flat),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Byte n of the frame: word n/BPW, byte n%BPW counted from the most significant end.
  function automatic logic [BYTE_W-1:0] model_byte(input words_t w, input int n);
    int unsigned v;
    int unsigned sh;
    v  = int'(w[n / BPW]);
    sh = BYTE_W * (BPW - 1 - (n % BPW));
    return BYTE_W'((v >> sh) % (1 << BYTE_W));
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      M_ALL1:   return 1'b1;
      M_TOGGLE: return (cyc % 2) == 1;
      M_STALL:  return cyc >= 100;
      default:  return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic run_frame(input int id, input words_t c, input words_t alt,
                           input int mode, input int restart_at, input int exp_busy);
    logic [BYTE_W-1:0] got[$];
    logic [BYTE_W-1:0] prev_data;
    logic [BYTE_W-1:0] done_data;
    logic              done_valid;
    logic              prev_stall;
    logic              done_seen;
    int                cyc, busy_cnt, done_cnt, stab_err;
    got.delete();
    cyc = 0; busy_cnt = 0; done_cnt = 0; stab_err = 0;
    prev_stall = 1'b0; prev_data = '0; done_seen = 1'b0;
    done_data = '0; done_valid = 1'b0;

    C_flat    = c;
    start     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("f%0d_first_valid", id), 32'(out_valid), 32'd1);
    check($sformatf("f%0d_first_busy", id), 32'(busy), 32'd1);
    check($sformatf("f%0d_first_byte", id), 32'(out_data), 32'(model_byte(c, 0)));

    while (!done_seen && cyc < 2000) begin
      if (cyc == restart_at) begin
        start  = 1'b1;
        C_flat = alt;
      end else begin
        start = 1'b0;
      end
      out_ready = ready_for(mode, cyc);
      @(negedge clk);
      if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (busy) busy_cnt++;
      if (done) begin
        done_seen  = 1'b1;
        done_cnt++;
        done_valid = out_valid;
        done_data  = out_data;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;

    check($sformatf("f%0d_timeout", id), 32'(done_seen), 32'd1);
    check($sformatf("f%0d_byte_count", id), 32'(got.size()), 32'(TOTAL));
    for (int k = 0; k < TOTAL; k++)
      if (k < got.size())
        check($sformatf("f%0d_byte%0d", id, k), 32'(got[k]), 32'(model_byte(c, k)));
    check($sformatf("f%0d_stall_hold", id), 32'(stab_err), 32'd0);
    check($sformatf("f%0d_done_count", id), 32'(done_cnt), 32'd1);
    check($sformatf("f%0d_fin_valid", id), 32'(done_valid), 32'd0);
    check($sformatf("f%0d_fin_data", id), 32'(done_data), 32'd0);
    if (exp_busy >= 0)
      check($sformatf("f%0d_busy_cycles", id), 32'(busy_cnt), 32'(exp_busy));

    @(negedge clk);
    check($sformatf("f%0d_after_done", id), 32'(done), 32'd0);
    check($sformatf("f%0d_after_valid", id), 32'(out_valid), 32'd0);
    check($sformatf("f%0d_after_busy", id), 32'(busy), 32'd0);
    @(posedge clk); #1;
    $display("[TB] frame %0d: mode %0d, %0d bytes, busy %0d cycles, %0d done pulse(s)",
             id, mode, got.size(), busy_cnt, done_cnt);
  endtask

  vec_t   vecs[6];
  words_t inc_w, max_w, mix_w, alt_w, rnd_w;

  initial begin
    for (int i = 0; i < N_ELEM; i++) begin
      inc_w[i] = RES_W'(i + 1);
      max_w[i] = '0;
      mix_w[i] = RES_W'(32'h1A5C3 * (i + 3));
      alt_w[i] = RES_W'(32'h2F0F0 ^ (i * 7));
    end
    max_w[0] = 18'h3FFFF;

    vecs[0] = '{c: inc_w, alt: inc_w, mode: M_ALL1,   restart_at: -1, exp_busy: 27};
    vecs[1] = '{c: max_w, alt: max_w, mode: M_ALL1,   restart_at: -1, exp_busy: 27};
    vecs[2] = '{c: mix_w, alt: mix_w, mode: M_TOGGLE, restart_at: -1, exp_busy: 54};
    vecs[3] = '{c: inc_w, alt: alt_w, mode: M_ALL1,   restart_at: 10, exp_busy: 27};
    vecs[4] = '{c: mix_w, alt: alt_w, mode: M_ALL1,   restart_at: 27, exp_busy: 27};
    vecs[5] = '{c: alt_w, alt: alt_w, mode: M_STALL,  restart_at: -1, exp_busy: 127};

    reset = 1'b1; start = 1'b0; C_flat = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);

    // start held across the last reset edge must not begin a frame
    C_flat = inc_w;
    start  = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_in_reset_valid", 32'(out_valid), 32'd0);
    check("start_in_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++)
      run_frame(v, vecs[v].c, vecs[v].alt, vecs[v].mode, vecs[v].restart_at, vecs[v].exp_busy);

    // Abort mid-frame while byte 5 is on the link
    C_flat    = inc_w;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_byte5", 32'(out_data), 32'(model_byte(inc_w, 5)));
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(out_data), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("[TB] abort at byte 5 done, restarting frame");
    run_frame(6, inc_w, inc_w, M_ALL1, -1, 27);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N_ELEM; i++) rnd_w[i] = RES_W'($urandom);
      run_frame(10 + r, rnd_w, rnd_w, (r < 2) ? M_ALL1 : M_RAND, -1, (r < 2) ? 27 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
